// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman sort/merge scheduler: default table
// geometry, the early-exit threshold and the scheduler state encoding.
package huff_pkg;

   localparam int DEF_N  = 6;
   localparam int DEF_CW = 8;
   localparam int DEF_IW = 6;
   localparam int DEF_AW = 3;

   // Consecutive swap-free phases after which the table is known sorted.
   localparam int QUIET_LIMIT = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SORT = 2'd1,
      ST_DONE = 2'd2,
      ST_HOLD = 2'd3
   } sched_state_t;

endpackage

// File: rtl/huff_cmp_swap.sv
// Compare-swap cell for one {count, mask} pair. The larger count goes to hi;
// equal counts keep their original order, which keeps the sort stable.
module huff_cmp_swap
   import huff_pkg::*;
#(
   parameter int CW = DEF_CW,
   parameter int IW = DEF_IW
) (
   input  logic [CW-1:0] a_cnt,
   input  logic [IW-1:0] a_id,
   input  logic [CW-1:0] b_cnt,
   input  logic [IW-1:0] b_id,
   output logic [CW-1:0] hi_cnt,
   output logic [IW-1:0] hi_id,
   output logic [CW-1:0] lo_cnt,
   output logic [IW-1:0] lo_id,
   output logic          swapped
);

   assign swapped = a_cnt < b_cnt;
   assign hi_cnt  = swapped ? b_cnt : a_cnt;
   assign hi_id   = swapped ? b_id  : a_id;
   assign lo_cnt  = swapped ? a_cnt : b_cnt;
   assign lo_id   = swapped ? a_id  : b_id;

endmodule

// File: rtl/huff_sort_sched.sv
// Sort/merge scheduler for the Huffman symbol-count table. Keeps the active
// entries in descending count order with an odd-even transposition sort (one
// phase per cycle), merges the two lowest active entries on request and
// answers the sort request level with a single sort_end pulse.
module huff_sort_sched
   import huff_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int CW = DEF_CW,
   parameter int IW = DEF_IW,
   parameter int AW = DEF_AW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load_valid,
   input  logic [N*CW-1:0] load_cnt,
   input  logic [N*IW-1:0] load_id,
   input  logic            sort_req,
   input  logic            merge_req,
   output logic            sort_end,
   output logic            busy,
   output logic [AW-1:0]   n_act,
   output logic [N*CW-1:0] cnt_out,
   output logic [N*IW-1:0] id_out,
   output logic            merge_err,
   output logic            ovf
);

   localparam logic [AW-1:0] ACT_TWO  = AW'(2);
   localparam logic [AW-1:0] ACT_FULL = AW'(N);
   localparam logic [1:0]    QUIET_MAX = 2'(QUIET_LIMIT);

   sched_state_t state_q, state_d;

   logic [CW-1:0] cnt_q [N];
   logic [CW-1:0] cnt_d [N];
   logic [IW-1:0] id_q  [N];
   logic [IW-1:0] id_d  [N];

   logic [AW-1:0] n_act_q;
   logic [AW-1:0] phase_q;
   logic [AW-1:0] phase_inc;
   logic          parity_q;
   logic [1:0]    quiet_q;
   logic [1:0]    quiet_d;
   logic          ovf_q;
   logic          merge_err_q;

   logic is_idle;
   logic in_sort;
   logic do_load;
   logic do_merge;
   logic merge_bad;
   logic go_sort;
   logic sort_finish;

   logic [CW-1:0] hi_cnt [N-1];
   logic [IW-1:0] hi_id  [N-1];
   logic [CW-1:0] lo_cnt [N-1];
   logic [IW-1:0] lo_id  [N-1];
   logic [N-2:0]  swapped;
   logic [N-2:0]  pair_act;
   logic          any_swap;

   logic [AW-1:0] idx_surv;
   logic [CW-1:0] surv_cnt;
   logic [IW-1:0] surv_id;
   logic [CW-1:0] tail_cnt;
   logic [IW-1:0] tail_id;
   logic [CW:0]   merge_sum;
   logic          merge_sat;
   logic [CW-1:0] merge_cnt;

   assign is_idle   = (state_q == ST_IDLE);
   assign in_sort   = (state_q == ST_SORT);
   assign do_load   = is_idle && load_valid;
   assign do_merge  = is_idle && !load_valid && merge_req && (n_act_q >= ACT_TWO);
   assign merge_bad = is_idle && !load_valid && merge_req && (n_act_q < ACT_TWO);
   assign go_sort   = is_idle && !load_valid && !merge_req && sort_req;

   // One compare-swap cell per adjacent pair; the parity mask picks which
   // cells are allowed to write back in the current phase.
   genvar gj;
   generate
      for (gj = 0; gj < N - 1; gj++) begin : g_pair
         huff_cmp_swap #(
            .CW (CW),
            .IW (IW)
         ) u_cmp_swap (
            .a_cnt   (cnt_q[gj]),
            .a_id    (id_q[gj]),
            .b_cnt   (cnt_q[gj+1]),
            .b_id    (id_q[gj+1]),
            .hi_cnt  (hi_cnt[gj]),
            .hi_id   (hi_id[gj]),
            .lo_cnt  (lo_cnt[gj]),
            .lo_id   (lo_id[gj]),
            .swapped (swapped[gj])
         );
      end
   endgenerate

   // A pair takes part in this phase if its left index has the current parity
   // and both of its entries are active.
   always_comb begin
      pair_act = '0;
      for (int j = 0; j < N - 1; j++) begin
         pair_act[j] = ((j % 2) == int'(parity_q)) && ((j + 1) < int'(n_act_q));
      end
   end

   assign any_swap    = |(pair_act & swapped);
   assign quiet_d     = any_swap ? 2'd0 : quiet_q + 2'd1;
   assign phase_inc   = phase_q + AW'(1);
   assign sort_finish = (n_act_q < ACT_TWO) || (phase_inc == n_act_q) ||
                        (quiet_d == QUIET_MAX);

   // Pick the two lowest active entries and form their saturating sum; the
   // survivor sits at n_act-2 and absorbs the tail entry at n_act-1.
   always_comb begin
      idx_surv = (n_act_q >= ACT_TWO) ? (n_act_q - ACT_TWO) : '0;
      surv_cnt = '0;
      surv_id  = '0;
      tail_cnt = '0;
      tail_id  = '0;
      for (int i = 0; i < N; i++) begin
         if (i == int'(idx_surv)) begin
            surv_cnt = cnt_q[i];
            surv_id  = id_q[i];
         end
         if (i == int'(idx_surv) + 1) begin
            tail_cnt = cnt_q[i];
            tail_id  = id_q[i];
         end
      end
      merge_sum = {1'b0, surv_cnt} + {1'b0, tail_cnt};
      merge_sat = merge_sum[CW];
      merge_cnt = merge_sat ? '1 : merge_sum[CW-1:0];
   end

   // Next table contents: load, merge or one sort phase, else hold.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         cnt_d[i] = cnt_q[i];
         id_d[i]  = id_q[i];
      end
      if (do_load) begin
         for (int i = 0; i < N; i++) begin
            cnt_d[i] = load_cnt[i*CW +: CW];
            id_d[i]  = load_id[i*IW +: IW];
         end
      end else if (do_merge) begin
         for (int i = 0; i < N; i++) begin
            if (i == int'(idx_surv)) begin
               cnt_d[i] = merge_cnt;
               id_d[i]  = surv_id | tail_id;
            end else if (i == int'(idx_surv) + 1) begin
               cnt_d[i] = '0;
               id_d[i]  = '0;
            end
         end
      end else if (in_sort) begin
         for (int j = 0; j < N - 1; j++) begin
            if (pair_act[j]) begin
               cnt_d[j]   = hi_cnt[j];
               id_d[j]    = hi_id[j];
               cnt_d[j+1] = lo_cnt[j];
               id_d[j+1]  = lo_id[j];
            end
         end
      end
   end

   // Table storage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            cnt_q[i] <= '0;
            id_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            cnt_q[i] <= cnt_d[i];
            id_q[i]  <= id_d[i];
         end
      end
   end

   // Scheduler state, active count, sort phase bookkeeping and flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         n_act_q     <= '0;
         phase_q     <= '0;
         parity_q    <= 1'b0;
         quiet_q     <= '0;
         ovf_q       <= 1'b0;
         merge_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         merge_err_q <= merge_bad;
         if (do_load) begin
            n_act_q <= ACT_FULL;
            ovf_q   <= 1'b0;
         end else if (do_merge) begin
            n_act_q <= n_act_q - AW'(1);
            if (merge_sat) begin
               ovf_q <= 1'b1;
            end
         end
         if (go_sort) begin
            phase_q  <= '0;
            parity_q <= 1'b0;
            quiet_q  <= '0;
         end else if (in_sort) begin
            phase_q  <= phase_inc;
            parity_q <= ~parity_q;
            quiet_q  <= quiet_d;
         end
      end
   end

   // Next-state logic; HOLD waits for the request level to drop so a level
   // that stays high never starts a second sort.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (go_sort)     state_d = ST_SORT;
         ST_SORT: if (sort_finish) state_d = ST_DONE;
         ST_DONE:                  state_d = ST_HOLD;
         ST_HOLD: if (!sort_req)   state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   assign sort_end  = (state_q == ST_DONE);
   assign busy      = !is_idle;
   assign n_act     = n_act_q;
   assign merge_err = merge_err_q;
   assign ovf       = ovf_q;

   genvar go;
   generate
      for (go = 0; go < N; go++) begin : g_out
         assign cnt_out[go*CW +: CW] = cnt_q[go];
         assign id_out[go*IW +: IW]  = id_q[go];
      end
   endgenerate

endmodule

// File: doc/huff_sort_sched.md
Name: huff_sort_sched

Overview:
- Sort/merge scheduler for the Huffman symbol-count table.
- Holds N {count, symbol-mask} entries and keeps them sorted by descending count using a stable odd-even transposition sort, one phase per cycle.
- Merges the two lowest entries on request.
- Answers the top-level Huffman control FSM's sort request level (count_en) with a one-cycle sort_end pulse.

Parameters:
- N, 6, number of table entries (symbols); N >= 2.
- CW, 8, count width in bits.
- IW, 6, symbol-mask width; IW >= N, bit i = symbol i.
- AW, 3, width of n_act; 2^AW > N.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; all state clears while low.
- load_valid  in  1  load all N entries from load_cnt/load_id; honoured in IDLE only.
- load_cnt  in  N*CW  flat counts; entry i at [i*CW +: CW].
- load_id  in  N*IW  flat masks; entry i at [i*IW +: IW].
- sort_req  in  1  level request; connects to control count_en.
- merge_req  in  1  pulse: merge the two lowest active entries; IDLE only.
- sort_end  out  1  one-cycle pulse, sort complete.
- busy  out  1  high when state != IDLE.
- n_act  out  AW  number of active entries.
- cnt_out  out  N*CW  current counts, same packing as load_cnt.
- id_out  out  N*IW  current masks, same packing as load_id.
- merge_err  out  1  one-cycle pulse: merge_req with n_act < 2.
- ovf  out  1  sticky flag, set by a saturating merge.

Behaviour:
- Reset values: all entries 0, n_act=0, state IDLE, sort_end=0, busy=0, merge_err=0, ovf=0. Reset mid-sort aborts with no sort_end.
- States: IDLE, SORT, DONE, HOLD.
- IDLE priority when several inputs are high in one cycle: load_valid > merge_req > sort_req.
  - Lower-priority requests that are ignored are not queued.
  - A sort_req still high next cycle is serviced then.
- load (IDLE): entries <= inputs; n_act <= N; ovf cleared.
- merge (IDLE, n_act >= 2), one cycle, with k = n_act-1:
  - cnt[k-1] <= sat(cnt[k-1] + cnt[k]).
  - id[k-1] <= id[k-1] | id[k].
  - cnt[k], id[k] <= 0.
  - n_act <= n_act-1.
  - Saturation: sum > 2^CW-1 gives 2^CW-1 and sets ovf.
  - The merge does not re-sort; control must issue sort_req after it.
- merge with n_act < 2: no state change; merge_err pulses next cycle.
- IDLE -> SORT when sort_req=1 and no load/merge that cycle. Phase counter = 0, parity = even, quiet counter = 0.
- SORT, one phase per cycle:
  - Compare-swap pairs (j, j+1) with j of the current parity and j+1 < n_act.
  - Swap only if cnt[j] < cnt[j+1] (strict), so equal counts keep their order (stable).
  - Entries at index >= n_act are never touched.
  - Parity toggles every phase.
  - quiet <= (no swap this phase) ? quiet+1 : 0.
- SORT -> DONE when phases done == n_act, or quiet reaches 2, or n_act < 2 (immediately, after one SORT cycle).
- DONE: sort_end=1 for exactly one cycle; then HOLD.
- HOLD: wait for sort_req=0, then IDLE. A level that stays high never causes a second sort.
- Latency from the IDLE cycle sampling sort_req=1: sort_end is high in cycle 3 (already sorted, n_act >= 2) up to n_act+1 (worst case).
- sort_req dropping during SORT: sort still completes and sort_end still pulses; HOLD then exits at once.
- load_valid or merge_req outside IDLE: ignored, no error.

Decomposition:
- Package huff_pkg: state encodings, default N/CW/IW, flat-bus slicing macros or functions.
- Sub-module huff_cmp_swap: CW+IW compare-swap cell giving outputs hi/lo and a swapped flag.
  - Instantiated floor(N/2) times per parity, or once per pair with muxed parity.
- FSM, counters and merge logic stay in the top module.

Test Plan:
- Stable sort:
  - Stimulus: load cnt=[3,12,7,7,1,20], id=one-hot [01,02,04,08,10,20] (hex); sort_req held high.
  - Required: cnt_out=[20,12,7,7,3,1], id_out=[20,02,04,08,01,10]; sort_end a single pulse within 7 cycles.
  - Required: after sort_req drops, state is IDLE and busy=0.
- Early exit:
  - Stimulus: load cnt=[9,8,7,6,5,4] (already sorted), then sort_req.
  - Required: sort_end in cycle 3 exactly; entries unchanged.
- Merge and re-sort:
  - Stimulus: on the sorted table from scenario 1, merge_req.
  - Required: n_act=5, cnt[4]=4, id[4]=11, cnt[5]=0, id[5]=0.
  - Stimulus: then sort_req.
  - Required: cnt_out=[20,12,7,7,4,0].
- Saturation and merge error:
  - Stimulus: load cnt=[0,0,0,0,200,100], then merge.
  - Required: cnt[4]=255, ovf=1.
  - Stimulus: reduce n_act to 1 with further merges, then merge_req.
  - Required: merge_err pulses; n_act stays 1.
- Priority: load_valid, merge_req and sort_req all high together in IDLE.
  - Required: only the load takes effect; sort starts next cycle with sort_req still high.
  - Required: no merge happens; n_act=6.
- Reset mid-sort:
  - Stimulus: drive reset low during the 2nd SORT cycle.
  - Required: all outputs 0 immediately (asynchronous); no sort_end after release.
